// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO feeding a UART core.
// Host pushes at full clock rate; bytes are popped one at a time and handed
// to the UART as a one-cycle transmit strobe plus byte, paced on the UART's
// is_transmitting status. Sticky flags report dropped pushes and a UART that
// never acknowledges a strobe.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  tx_error,
  input  logic                  clr_flags,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
  input  logic                  is_transmitting
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [3:0] TMO = 4'(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;

  logic [7:0]    mem_q [DEPTH];
  state_t        state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          overflow_q, overflow_d, tx_error_q, tx_error_d;
  logic          transmit_q, transmit_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [3:0]    timer_q, timer_d;
  logic          push_ok, pop, err_set;

  // Full is judged on the registered flag: a push while full is dropped even
  // if a pop frees a slot on the same edge.
  assign push_ok = wr_en & ~full_q;
  assign pop     = (state_q == IDLE) & ~empty_q & ~is_transmitting;

  // Next-state for pointers, occupancy, flags and the handshake FSM.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    timer_d    = timer_q;
    err_set    = 1'b0;

    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_byte_d  = mem_q[rd_ptr_q];
          transmit_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + PW'(1);
          timer_d    = TMO;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (is_transmitting) begin
          state_d = WAIT_DONE;
        end else if (timer_q == 4'd1) begin
          // UART never went busy: byte is abandoned, not retried.
          timer_d = 4'd0;
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      WAIT_DONE: begin
        if (!is_transmitting) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);

    // Sticky flags: a set event beats a simultaneous clear.
    overflow_d = (wr_en & full_q) ? 1'b1 : (clr_flags ? 1'b0 : overflow_q);
    tx_error_d = err_set          ? 1'b1 : (clr_flags ? 1'b0 : tx_error_q);
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_error_q <= 1'b0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_error_q <= tx_error_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
      timer_q    <= timer_d;
    end
  end

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_error = tx_error_q;
  assign transmit = transmit_q;
  assign tx_byte  = tx_byte_q;

endmodule
